// File: rtl/cv32e40p_alu_ft_pkg.sv
// Shared types and defaults for the TMR ALU reconfiguration controller.
// Optional build macro used by the manager: CV32E40P_ALU_FT_STATS_EN.
package cv32e40p_alu_ft_pkg;

  // Voter operating mode, driven straight onto the voter mux select.
  typedef enum logic [1:0] {
    VM_TMR    = 2'b00,
    VM_DMR    = 2'b01,
    VM_SINGLE = 2'b10,
    VM_FATAL  = 2'b11
  } vote_mode_e;

  // Health state of one replica (or of the DMR pair).
  typedef enum logic [1:0] {
    RS_OK      = 2'b00,
    RS_SUSPECT = 2'b01,
    RS_RETIRED = 2'b10
  } replica_state_e;

  localparam int unsigned DEF_ERR_THRESH = 100;
  localparam int unsigned DEF_WIN_LEN    = 1024;
  localparam int unsigned DEF_CNT_W      = 7;

  // Voter mode implied by the set of still-active replicas.
  function automatic vote_mode_e mode_from_mask(input logic [2:0] en);
    vote_mode_e m;
    case (en)
      3'b111:                 m = VM_TMR;
      3'b011, 3'b101, 3'b110: m = VM_DMR;
      3'b001, 3'b010, 3'b100: m = VM_SINGLE;
      default:                m = VM_FATAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cv32e40p_alu_ft_err_cnt.sv
// Windowed error counter with OK/SUSPECT/RETIRED health FSM for one replica
// (also used for the shared DMR pair counter). A counter that reaches the
// threshold raises retire_req_o and holds there, window wraps included, until
// the manager grants the retirement.
module cv32e40p_alu_ft_err_cnt
  import cv32e40p_alu_ft_pkg::*;
#(
  parameter int unsigned ERR_THRESH = DEF_ERR_THRESH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           count_en_i,
  input  logic           win_wrap_i,
  input  logic           retire_grant_i,
  input  logic           clear_i,
  output replica_state_e state_o,
  output logic           retire_req_o
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  replica_state_e   state_q;
  logic             retired;
  logic             pending;

  assign retired = (state_q == RS_RETIRED);
  // At threshold but not yet granted: waiting behind a lower-index retirement.
  assign pending = !retired && (count_q == THRESH);

  assign retire_req_o = pending ||
                        (!retired && count_en_i && ((count_q + ONE) == THRESH));
  assign state_o      = state_q;

  // Counter and health FSM; a wrap restarts the count, keeping a same-cycle hit.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      state_q <= RS_OK;
    end else if (clear_i) begin
      count_q <= '0;
      state_q <= RS_OK;
    end else if (retire_grant_i) begin
      state_q <= RS_RETIRED;
    end else if (!retired && !pending) begin
      if (win_wrap_i) begin
        count_q <= count_en_i ? ONE : '0;
        state_q <= count_en_i ? RS_SUSPECT : RS_OK;
      end else if (count_en_i) begin
        count_q <= count_q + ONE;
        state_q <= RS_SUSPECT;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_alu_ft_manager.sv
// Reconfiguration controller for the triplicated ALU: counts per-replica
// voter mismatches in decaying windows, retires failing replicas one per
// cycle and steps the voter TMR -> DMR -> SINGLE, or to FATAL.
// alu_valid_i qualifies mismatch_i and vote_fail_i; there is no back-pressure.
// Build macro CV32E40P_ALU_FT_STATS_EN adds err_total_o lifetime counters.
module cv32e40p_alu_ft_manager
  import cv32e40p_alu_ft_pkg::*;
#(
  parameter int unsigned NUM_ALU    = 3,
  parameter int unsigned ERR_THRESH = DEF_ERR_THRESH,
  parameter int unsigned WIN_LEN    = DEF_WIN_LEN,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               alu_valid_i,
  input  logic [NUM_ALU-1:0] mismatch_i,
  input  logic               vote_fail_i,
  input  logic               clear_i,
  output logic [NUM_ALU-1:0] alu_en_o,
  output logic [1:0]         vote_mode_o,
  output logic               fatal_o,
  output logic               retire_pulse_o
`ifdef CV32E40P_ALU_FT_STATS_EN
  ,
  output logic [NUM_ALU*16-1:0] err_total_o
`endif
);

  localparam int unsigned      WIN_W    = $clog2(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  logic [WIN_W-1:0]   win_q;
  logic               win_wrap;

  logic [NUM_ALU-1:0] alu_en_q;
  vote_mode_e         mode_q;
  logic               fatal_q;
  logic               pulse_q;

  replica_state_e     rep_state [NUM_ALU];
  logic [NUM_ALU-1:0] rep_cnt_en;
  logic [NUM_ALU-1:0] rep_req;
  logic [NUM_ALU-1:0] rep_grant;
  logic [NUM_ALU-1:0] fsm_grant;
  logic [NUM_ALU-1:0] en_d;

  replica_state_e     pair_state;
  logic               pair_cnt_en;
  logic               pair_req;
  logic               pair_grant;
  logic               grant_any;
  logic               would_fatal;
  logic               fatal_d;

  // Decay window: one tick per valid ALU op, wrapping after WIN_LEN ops.
  assign win_wrap = alu_valid_i && (win_q == WIN_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (clear_i) begin
      win_q <= '0;
    end else if (alu_valid_i) begin
      win_q <= win_wrap ? '0 : (win_q + WIN_ONE);
    end
  end

  // Per-replica counters only run while all three replicas are voting.
  for (genvar i = 0; i < NUM_ALU; i++) begin : g_rep
    assign rep_cnt_en[i] = alu_valid_i && mismatch_i[i] && alu_en_q[i] &&
                           (rep_state[i] != RS_RETIRED) && (mode_q == VM_TMR);

    cv32e40p_alu_ft_err_cnt #(
      .ERR_THRESH (ERR_THRESH),
      .CNT_W      (CNT_W)
    ) u_err_cnt (
      .clock          (clock),
      .rst_n          (rst_n),
      .count_en_i     (rep_cnt_en[i]),
      .win_wrap_i     (win_wrap),
      .retire_grant_i (fsm_grant[i]),
      .clear_i        (clear_i),
      .state_o        (rep_state[i]),
      .retire_req_o   (rep_req[i])
    );
  end

  // In DMR a single disagreement counter covers the remaining pair.
  assign pair_cnt_en = alu_valid_i && vote_fail_i && (mode_q == VM_DMR) &&
                       (pair_state != RS_RETIRED);

  cv32e40p_alu_ft_err_cnt #(
    .ERR_THRESH (ERR_THRESH),
    .CNT_W      (CNT_W)
  ) u_pair_cnt (
    .clock          (clock),
    .rst_n          (rst_n),
    .count_en_i     (pair_cnt_en),
    .win_wrap_i     (win_wrap),
    .retire_grant_i (pair_grant && !would_fatal),
    .clear_i        (clear_i),
    .state_o        (pair_state),
    .retire_req_o   (pair_req)
  );

  // One retirement per cycle: lowest requesting replica first; a pair failure
  // then drops the lower active replica so the highest index keeps running.
  always_comb begin
    rep_grant  = '0;
    pair_grant = 1'b0;
    grant_any  = 1'b0;
    if (!fatal_q) begin
      for (int i = 0; i < NUM_ALU; i++) begin
        if (rep_req[i] && !grant_any) begin
          rep_grant[i] = 1'b1;
          grant_any    = 1'b1;
        end
      end
      if (!grant_any && pair_req && (mode_q == VM_DMR)) begin
        pair_grant = 1'b1;
        for (int i = 0; i < NUM_ALU; i++) begin
          if (alu_en_q[i] && !grant_any) begin
            rep_grant[i] = 1'b1;
            grant_any    = 1'b1;
          end
        end
      end
    end
  end

  // Retiring the last active replica is refused and escalates to FATAL.
  assign would_fatal = grant_any && ((alu_en_q & ~rep_grant) == '0);
  assign fsm_grant   = would_fatal ? '0 : rep_grant;
  assign en_d        = alu_en_q & ~fsm_grant;
  assign fatal_d     = fatal_q || would_fatal;

  // Registered outputs: mask, mode, sticky fatal and the retirement pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      alu_en_q <= '1;
      mode_q   <= VM_TMR;
      fatal_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else if (clear_i) begin
      alu_en_q <= '1;
      mode_q   <= VM_TMR;
      fatal_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      alu_en_q <= en_d;
      mode_q   <= fatal_d ? VM_FATAL : mode_from_mask(en_d);
      fatal_q  <= fatal_d;
      pulse_q  <= grant_any && !would_fatal;
    end
  end

  assign alu_en_o       = alu_en_q;
  assign vote_mode_o    = mode_q;
  assign fatal_o        = fatal_q;
  assign retire_pulse_o = pulse_q;

`ifdef CV32E40P_ALU_FT_STATS_EN
  logic [15:0] tot_q [NUM_ALU];

  // Lifetime mismatch totals, saturating, independent of mode or retirement.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALU; i++) tot_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_ALU; i++) tot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ALU; i++) begin
        if (alu_valid_i && mismatch_i[i] && (tot_q[i] != 16'hFFFF)) begin
          tot_q[i] <= tot_q[i] + 16'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_tot
    assign err_total_o[i*16 +: 16] = tot_q[i];
  end
`endif

endmodule

// File: tb/tb_cv32e40p_alu_ft_manager.sv
// Bench for the TMR ALU reconfiguration controller: directed vectors, a
// behavioural reference model, a per-cycle output compare and literal
// expectations at the key points of each scenario.
module tb_cv32e40p_alu_ft_manager;

  localparam int         THRESH = 100;
  localparam int         WIN    = 1024;
  localparam logic [1:0] TMR    = 2'b00;
  localparam logic [1:0] DMR    = 2'b01;
  localparam logic [1:0] SGL    = 2'b10;
  localparam logic [1:0] FTL    = 2'b11;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic       alu_valid_i = 1'b0;
  logic [2:0] mismatch_i  = 3'b000;
  logic       vote_fail_i = 1'b0;
  logic       clear_i     = 1'b0;
  logic [2:0] alu_en_o;
  logic [1:0] vote_mode_o;
  logic       fatal_o;
  logic       retire_pulse_o;
`ifdef CV32E40P_ALU_FT_STATS_EN
  logic [47:0] err_total_o;
`endif

  cv32e40p_alu_ft_manager dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .alu_valid_i    (alu_valid_i),
    .mismatch_i     (mismatch_i),
    .vote_fail_i    (vote_fail_i),
    .clear_i        (clear_i),
    .alu_en_o       (alu_en_o),
    .vote_mode_o    (vote_mode_o),
    .fatal_o        (fatal_o),
    .retire_pulse_o (retire_pulse_o)
`ifdef CV32E40P_ALU_FT_STATS_EN
    ,
    .err_total_o    (err_total_o)
`endif
  );

  // ---------------- reference model ----------------
  int         m_cnt [3];
  int         m_pair;
  int         m_win;
  bit         m_ret [3];
  logic [2:0] m_en;
  logic       m_fatal;
  logic       m_pulse;
  int         m_tot [3];

  function automatic logic [1:0] mode_of(input logic [2:0] en, input logic fatal);
    if (fatal) return FTL;
    case ($countones(en))
      3:       return TMR;
      2:       return DMR;
      1:       return SGL;
      default: return FTL;
    endcase
  endfunction

  // A count that has hit the threshold just waits for its turn to retire.
  function automatic int decay_add(input int c, input int hit, input bit wrap);
    if (c == THRESH) return c;
    if (wrap) return hit;
    return c + hit;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_ret[i] = 1'b0;
      m_tot[i] = 0;
    end
    m_pair  = 0;
    m_win   = 0;
    m_en    = 3'b111;
    m_fatal = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] cur;
    bit         wrap;
    int         hit;
    int         victim;
    int         keep;
    cur  = mode_of(m_en, m_fatal);
    wrap = alu_valid_i && (m_win == WIN - 1);
    if (alu_valid_i) m_win = wrap ? 0 : m_win + 1;
    for (int i = 0; i < 3; i++) begin
      if (alu_valid_i && mismatch_i[i] && m_tot[i] < 65535) m_tot[i]++;
      hit = (alu_valid_i && mismatch_i[i] && cur == TMR) ? 1 : 0;
      if (!m_ret[i]) m_cnt[i] = decay_add(m_cnt[i], hit, wrap);
    end
    hit    = (alu_valid_i && vote_fail_i && cur == DMR) ? 1 : 0;
    m_pair = decay_add(m_pair, hit, wrap);
    m_pulse = 1'b0;
    if (!m_fatal) begin
      victim = -1;
      for (int i = 0; i < 3; i++)
        if (victim < 0 && !m_ret[i] && m_cnt[i] == THRESH) victim = i;
      if (victim < 0 && cur == DMR && m_pair == THRESH) begin
        keep = -1;
        for (int i = 0; i < 3; i++) if (m_en[i]) keep = i;
        for (int i = 0; i < 3; i++) if (victim < 0 && m_en[i] && i != keep) victim = i;
      end
      if (victim >= 0) begin
        if ($countones(m_en) == 1) begin
          m_fatal = 1'b1;
        end else begin
          m_en[victim]  = 1'b0;
          m_ret[victim] = 1'b1;
          m_pulse       = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n || clear_i) model_reset();
    else model_step();
  end

  // ---------------- scoreboard / compare ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       lit_on  = 1'b0;
  string      lit_name = "";
  logic [2:0] lit_en;
  logic [1:0] lit_mode;
  logic       lit_fatal;
  logic       lit_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    check("en_vs_model", 32'(alu_en_o), 32'(m_en));
    check("mode_vs_model", 32'(vote_mode_o), 32'(mode_of(m_en, m_fatal)));
    check("fatal_vs_model", 32'(fatal_o), 32'(m_fatal));
    check("pulse_vs_model", 32'(retire_pulse_o), 32'(m_pulse));
`ifdef CV32E40P_ALU_FT_STATS_EN
    for (int i = 0; i < 3; i++)
      check("total_vs_model", 32'(err_total_o[i*16 +: 16]), 32'(m_tot[i]));
`endif
    if (lit_on) begin
      check({lit_name, "_en"}, 32'(alu_en_o), 32'(lit_en));
      check({lit_name, "_mode"}, 32'(vote_mode_o), 32'(lit_mode));
      check({lit_name, "_fatal"}, 32'(fatal_o), 32'(lit_fatal));
      check({lit_name, "_pulse"}, 32'(retire_pulse_o), 32'(lit_pulse));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [2:0] m, input logic f, input logic c);
    alu_valid_i = v;
    mismatch_i  = m;
    vote_fail_i = f;
    clear_i     = c;
    @(posedge clock);
    #1;
    alu_valid_i = 1'b0;
    mismatch_i  = 3'b000;
    vote_fail_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  task automatic ops(input int n, input logic [2:0] m, input logic f);
    repeat (n) drive(1'b1, m, f, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic [2:0] en, input logic [1:0] mode,
                            input logic fatal, input logic pulse);
    lit_name  = name;
    lit_en    = en;
    lit_mode  = mode;
    lit_fatal = fatal;
    lit_pulse = pulse;
    lit_on    = 1'b1;
    @(negedge clock);
    #1;
    lit_on = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset", 3'b111, TMR, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    // Replica 1 accumulates exactly the threshold inside one window.
    ops(99, 3'b010, 1'b0);
    expect_out("t1_99", 3'b111, TMR, 1'b0, 1'b0);
    ops(1, 3'b010, 1'b0);
    expect_out("t1_retire", 3'b101, DMR, 1'b0, 1'b1);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    expect_out("t1_pulse_once", 3'b101, DMR, 1'b0, 1'b0);
    ops(120, 3'b111, 1'b0);
    expect_out("t1_dmr_ignores_mismatch", 3'b101, DMR, 1'b0, 1'b0);

    // Window decay, with a hit on the wrap cycle itself counting as 1.
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    expect_out("t2_clear", 3'b111, TMR, 1'b0, 1'b0);
    ops(60, 3'b001, 1'b0);
    ops(963, 3'b000, 1'b0);
    ops(1, 3'b001, 1'b0);
    ops(59, 3'b001, 1'b0);
    expect_out("t2_after_wrap", 3'b111, TMR, 1'b0, 1'b0);
    ops(39, 3'b001, 1'b0);
    expect_out("t2_99", 3'b111, TMR, 1'b0, 1'b0);
    ops(1, 3'b001, 1'b0);
    expect_out("t2_retire", 3'b110, DMR, 1'b0, 1'b1);

    // Replicas 0 and 2 hit the threshold together: serialised retirements.
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    ops(99, 3'b101, 1'b0);
    expect_out("t3_99", 3'b111, TMR, 1'b0, 1'b0);
    ops(1, 3'b101, 1'b0);
    expect_out("t3_first", 3'b110, DMR, 1'b0, 1'b1);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    expect_out("t3_second", 3'b010, SGL, 1'b0, 1'b1);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    expect_out("t3_settle", 3'b010, SGL, 1'b0, 1'b0);

    // DMR on 3'b011, pair disagreements drop replica 0.
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    ops(100, 3'b100, 1'b0);
    expect_out("t4_dmr", 3'b011, DMR, 1'b0, 1'b1);
    ops(99, 3'b011, 1'b1);
    expect_out("t4_pair99", 3'b011, DMR, 1'b0, 1'b0);
    ops(1, 3'b011, 1'b1);
    expect_out("t4_single", 3'b010, SGL, 1'b0, 1'b1);
    ops(150, 3'b111, 1'b1);
    expect_out("t4_single_hold", 3'b010, SGL, 1'b0, 1'b0);

    // Clear from SINGLE wins over a coincident mismatch.
    drive(1'b1, 3'b111, 1'b1, 1'b1);
    expect_out("t5_clear", 3'b111, TMR, 1'b0, 1'b0);
    ops(99, 3'b100, 1'b0);
    expect_out("t5_99", 3'b111, TMR, 1'b0, 1'b0);
    ops(1, 3'b100, 1'b0);
    expect_out("t5_retire", 3'b011, DMR, 1'b0, 1'b1);

    // All three reach threshold: the last retirement becomes FATAL.
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    ops(99, 3'b111, 1'b0);
    expect_out("tf_99", 3'b111, TMR, 1'b0, 1'b0);
    ops(1, 3'b111, 1'b0);
    expect_out("tf_first", 3'b110, DMR, 1'b0, 1'b1);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    expect_out("tf_second", 3'b100, SGL, 1'b0, 1'b1);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    expect_out("tf_fatal", 3'b100, FTL, 1'b1, 1'b0);
    ops(20, 3'b111, 1'b1);
    expect_out("tf_sticky", 3'b100, FTL, 1'b1, 1'b0);

    // Asynchronous reset mid-window discards partial counts.
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    ops(100, 3'b100, 1'b0);
    expect_out("t6_dmr", 3'b011, DMR, 1'b0, 1'b1);
    ops(50, 3'b000, 1'b1);
    expect_out("t6_pair50", 3'b011, DMR, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    rst_n = 1'b0;
    expect_out("t6_async", 3'b111, TMR, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    ops(99, 3'b001, 1'b0);
    expect_out("t6_99", 3'b111, TMR, 1'b0, 1'b0);
    ops(1, 3'b001, 1'b0);
    expect_out("t6_retire", 3'b110, DMR, 1'b0, 1'b1);
    ops(99, 3'b000, 1'b1);
    expect_out("t6_pair99", 3'b110, DMR, 1'b0, 1'b0);
    ops(1, 3'b000, 1'b1);
    expect_out("t6_pair_single", 3'b100, SGL, 1'b0, 1'b1);

    repeat (3) drive(1'b0, 3'b000, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
